retro_memory_responder: RTL

- Target-side responder for the IRetroMemoryPort protocol; it is the memory end that an initiator (e.g. the cache's Storage or Source port) talks to.
- Backs the port with an internal block-RAM array.
- Models fixed read latency and programmable wait states so cartridge ROM/SDRAM timing can be emulated.
- Supports pipelined accesses: in-order completion, one request accepted per cycle when WaitStates is 0.

---
 rtl/retro_memory_pkg.sv | 25 ++
 rtl/retro_latency_pipe.sv | 83 ++++++++
 rtl/retro_memory_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/retro_memory_pkg.sv
// rtl/retro_memory_pkg.sv - shared types, limits and width helper for the retro memory responder
//
// Purpose: common definitions imported by the responder top and its latency pipe.
// Ports: none (package).

package retro_memory_pkg;

    // Upper bounds on the timing knobs; out-of-range parameters are clamped to these.
    localparam int MaxReadLatency     = 4;
    localparam int MaxWaitStates      = 15;

    // Widest address the request record can carry; the top uses only its low bits.
    localparam int MaxAddressBusWidth = 32;

    typedef struct packed {
        logic                          write;
        logic [MaxAddressBusWidth-1:0] address;
    } retro_mem_req_t;

    // Data bus width in bits for a bus of the given number of bytes.
    function automatic int byte_bits(input int bytes);
        return 8 * bytes;
    endfunction

endpackage

// File: rtl/retro_latency_pipe.sv
// rtl/retro_latency_pipe.sv - fixed-depth completion pipe carrying valid, write flag and read data
//
// Purpose: delays each accepted request by Depth clock edges, then presents a
//          one-cycle completion pulse. Read data is captured into a holding
//          register at completion; write completions leave it untouched.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high clear of every stage
//   in_valid   in   request accepted on this edge
//   in_write   in   accepted request is a write
//   in_data    in   array read data for the accepted request
//   out_valid  out  registered completion pulse
//   out_data   out  last completed read data (held between read completions)

module retro_latency_pipe #(
    parameter int Depth = 2,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_write,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    // Values about to be loaded into the output registers on the next edge.
    logic             tail_valid;
    logic             tail_write;
    logic [Width-1:0] tail_data;

    generate
        if (Depth <= 1) begin : g_direct
            // Single-cycle latency: the output register is the only stage.
            assign tail_valid = in_valid;
            assign tail_write = in_write;
            assign tail_data  = in_data;
        end else begin : g_shift
            logic [Depth-2:0] vld;
            logic [Depth-2:0] wr;
            logic [Width-1:0] dat [Depth-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= '0;
                    wr  <= '0;
                    for (int i = 0; i < Depth - 1; i++) begin
                        dat[i] <= '0;
                    end
                end else begin
                    // Advances every cycle, so a new request can enter while
                    // the oldest one leaves on the same edge.
                    vld[0] <= in_valid;
                    wr[0]  <= in_write;
                    dat[0] <= in_data;
                    for (int i = 1; i < Depth - 1; i++) begin
                        vld[i] <= vld[i-1];
                        wr[i]  <= wr[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            assign tail_valid = vld[Depth-2];
            assign tail_write = wr[Depth-2];
            assign tail_data  = dat[Depth-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tail_valid;
            if (tail_valid && !tail_write) begin
                out_data <= tail_data;
            end
        end
    end

endmodule

// File: rtl/retro_memory_responder.sv
// rtl/retro_memory_responder.sv - memory-side responder with fixed read latency and wait states
//
// Purpose: target end of the retro memory port. Backs the port with an
//          internal word array, completes requests in order after
//          ReadLatency cycles and throttles acceptance with WaitStates idle
//          cycles to emulate slow cartridge ROM / SDRAM.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   access      in   request strobe, taken when access && ready at an edge
//   write       in   1 = write, 0 = read
//   address     in   word address
//   din         in   write data
//   dout        out  read data, held until the next read completion
//   ready       out  a request can be accepted this cycle
//   data_ready  out  one-cycle completion pulse for the oldest request

module retro_memory_responder
    import retro_memory_pkg::*;
#(
    parameter int AddressBusWidth = 14,
    parameter int DataBusWidth    = 1,
    parameter int ReadLatency     = 2,
    parameter int WaitStates      = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               access,
    input  logic                               write,
    input  logic [AddressBusWidth-1:0]         address,
    input  logic [byte_bits(DataBusWidth)-1:0] din,
    output logic [byte_bits(DataBusWidth)-1:0] dout,
    output logic                               ready,
    output logic                               data_ready
);

    localparam int DataBits  = byte_bits(DataBusWidth);
    localparam int Words     = 1 << AddressBusWidth;

    // Timing knobs outside their legal range are clamped rather than
    // producing a degenerate pipe or an overflowing counter.
    localparam int Latency   = (ReadLatency < 1) ? 1 :
                               (ReadLatency > MaxReadLatency) ? MaxReadLatency : ReadLatency;
    localparam int Waits     = (WaitStates < 0) ? 0 :
                               (WaitStates > MaxWaitStates) ? MaxWaitStates : WaitStates;
    localparam int CntBits   = $clog2(MaxWaitStates + 1);

    localparam logic [CntBits-1:0] WaitLoad = CntBits'(Waits);
    localparam logic               NoWaits  = (Waits == 0);

    logic [DataBits-1:0]        mem [Words];
    retro_mem_req_t             req;
    logic [AddressBusWidth-1:0] word_addr;
    logic                       accept;
    logic [DataBits-1:0]        rd_data;
    logic [CntBits-1:0]         wait_cnt;

    assign req       = '{write: write, address: MaxAddressBusWidth'(address)};
    assign word_addr = req.address[AddressBusWidth-1:0];
    assign accept    = access && ready;

    // Array contents survive reset: writes accepted before a reset stay put.
    always_ff @(posedge clk) begin
        if (accept && req.write) begin
            mem[word_addr] <= din;
        end
    end

    // Read at the acceptance edge; a read accepted one edge after a write to
    // the same word therefore sees the new data.
    assign rd_data = mem[word_addr];

    // ready is registered from the next counter value so it reads as
    // (counter == 0) without a combinational path from the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            ready    <= 1'b0;
        end else if (accept) begin
            wait_cnt <= WaitLoad;
            ready    <= NoWaits;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CntBits'(1);
            ready    <= (wait_cnt == CntBits'(1));
        end else begin
            ready    <= 1'b1;
        end
    end

    retro_latency_pipe #(
        .Depth (Latency),
        .Width (DataBits)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_write  (req.write),
        .in_data   (rd_data),
        .out_valid (data_ready),
        .out_data  (dout)
    );

endmodule
